// File: rtl/cmp_pkg.sv
// Shared types and default sizes for the LSU with store buffer.
// Imported by the interface, the store buffer and the LSU top.
package cmp_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_RD_W     = 5;
  localparam int DEF_SB_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_REQ  = 3'd1,
    LD_REQ  = 3'd2,
    LD_WAIT = 3'd3,
    LD_DONE = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/cmp_lsu_if.sv
// Memory-side bus between the LSU (master) and the memory (slave).
// Requests are held until mem_gnt; read data returns on mem_rvalid.
interface cmp_lsu_if
  import cmp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              mem_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d_out;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_d_in;
  logic              mem_rvalid;

  modport master (
    output mem_en, mem_wr_en, mem_addr, mem_d_out,
    input  mem_gnt, mem_d_in, mem_rvalid
  );

  modport slave (
    input  mem_en, mem_wr_en, mem_addr, mem_d_out,
    output mem_gnt, mem_d_in, mem_rvalid
  );

endinterface

// File: rtl/cmp_store_buf.sv
// In-order store FIFO with occupancy count and a youngest-match
// address lookup used to forward store data to loads.
module cmp_store_buf
  import cmp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [ADDR_W-1:0]               push_addr,
  input  logic [DATA_W-1:0]               push_data,
  input  logic                            pop,
  output logic [ADDR_W-1:0]               head_addr,
  output logic [DATA_W-1:0]               head_data,
  input  logic [ADDR_W-1:0]               lk_addr,
  output logic                            lk_hit,
  output logic [DATA_W-1:0]               lk_data,
  output logic [$clog2(SB_DEPTH+1)-1:0]   count,
  output logic                            full,
  output logic                            empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH+1);

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     idx;

  // Pointer and occupancy update; push+pop keeps the count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointer and count registers; reset discards pending stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q && addr_q[idx] == lk_addr) begin
        lk_hit  = 1'b1;
        lk_data = data_q[idx];
      end
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == CW'(SB_DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/cmp_lsu.sv
// Load/store unit: buffers stores and drains them in order, forwards
// buffered data to hitting loads, and fetches missing loads from memory.
module cmp_lsu
  import cmp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_W     = DEF_RD_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_wr,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_data,
  input  logic [RD_W-1:0]               req_rd,
  output logic                          req_ready,
  output logic                          ld_valid,
  output logic [RD_W-1:0]               ld_rd,
  output logic [DATA_W-1:0]             ld_data,
  cmp_lsu_if.master                     mem,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic                          sb_empty
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [RD_W-1:0]   ld_tag_q, ld_tag_d;
  logic [DATA_W-1:0] ld_buf_q, ld_buf_d;
  logic              ld_valid_q, ld_valid_d;
  logic [RD_W-1:0]   ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;

  logic              sb_push, sb_pop, sb_full;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              is_ld, ld_hit_acc, ld_miss, ld_done_acc;

  cmp_store_buf #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .push      (sb_push),
    .push_addr (req_addr),
    .push_data (req_data),
    .pop       (sb_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .lk_addr   (req_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data),
    .count     (sb_count),
    .full      (sb_full),
    .empty     (sb_empty)
  );

  // Request classification; stores bypass the FSM and only need space.
  always_comb begin
    is_ld       = req_valid && !req_wr;
    ld_hit_acc  = is_ld && state_q == IDLE && lk_hit;
    ld_miss     = is_ld && state_q == IDLE && !lk_hit;
    ld_done_acc = is_ld && state_q == LD_DONE;
    sb_push     = req_valid && req_wr && !sb_full && !reset;
    sb_pop      = state_q == ST_REQ && mem.mem_gnt;
    req_ready   = 1'b0;
    if (req_valid && !reset) begin
      if (req_wr) req_ready = !sb_full;
      else        req_ready = ld_hit_acc || ld_done_acc;
    end
  end

  // Next-state and writeback; load misses win over starting a drain.
  always_comb begin
    state_d    = state_q;
    ld_addr_d  = ld_addr_q;
    ld_tag_d   = ld_tag_q;
    ld_buf_d   = ld_buf_q;
    ld_valid_d = 1'b0;
    ld_rd_d    = ld_rd_q;
    ld_data_d  = ld_data_q;
    unique case (state_q)
      IDLE: begin
        if (ld_miss) begin
          state_d   = LD_REQ;
          ld_addr_d = req_addr;
          ld_tag_d  = req_rd;
        end else if (!sb_empty) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ:  if (mem.mem_gnt) state_d = IDLE;
      LD_REQ:  if (mem.mem_gnt) state_d = LD_WAIT;
      LD_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d  = LD_DONE;
          ld_buf_d = mem.mem_d_in;
        end
      end
      LD_DONE: if (ld_done_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ld_hit_acc) begin
      ld_valid_d = 1'b1;
      ld_rd_d    = req_rd;
      ld_data_d  = lk_data;
    end
    if (ld_done_acc) begin
      ld_valid_d = 1'b1;
      ld_rd_d    = ld_tag_q;
      ld_data_d  = ld_buf_q;
    end
    mem_en_d = state_d == ST_REQ || state_d == LD_REQ;
    mem_wr_d = state_d == ST_REQ;
  end

  // FSM state, load capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ld_addr_q  <= '0;
      ld_tag_q   <= '0;
      ld_buf_q   <= '0;
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
      ld_data_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_addr_q  <= ld_addr_d;
      ld_tag_q   <= ld_tag_d;
      ld_buf_q   <= ld_buf_d;
      ld_valid_q <= ld_valid_d;
      ld_rd_q    <= ld_rd_d;
      ld_data_q  <= ld_data_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign ld_valid      = ld_valid_q;
  assign ld_rd         = ld_rd_q;
  assign ld_data       = ld_data_q;
  assign mem.mem_en    = mem_en_q;
  assign mem.mem_wr_en = mem_wr_q;
  assign mem.mem_addr  = (state_q == LD_REQ) ? ld_addr_q : head_addr;
  assign mem.mem_d_out = head_data;

endmodule

// File: tb/tb_cmp_lsu.sv
// Directed bench for cmp_lsu: a cycle table covering forwarding,
// ordered drain and a load miss, plus full-buffer and reset sequences.
module tb_cmp_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wr;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  cmp_lsu_if #(.ADDR_W(32), .DATA_W(64)) mif ();

  cmp_lsu dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rd    (req_rd),
    .req_ready (req_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .mem       (mif.master),
    .sb_count  (sb_count),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        gnt, rv;
    logic [63:0] din;
    logic        e_rdy, e_ldv;
    logic [63:0] e_ldd;
    logic [4:0]  e_rd;
    logic        e_men, e_mwr;
    logic [31:0] e_maddr;
    logic [63:0] e_mdout;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic v, logic wr, logic [31:0] addr, logic [63:0] data,
    logic [4:0] rd, logic gnt, logic rv, logic [63:0] din,
    logic e_rdy, logic e_ldv, logic [63:0] e_ldd, logic [4:0] e_rd,
    logic e_men, logic e_mwr, logic [31:0] e_maddr,
    logic [63:0] e_mdout, logic [2:0] e_cnt);
    vec_t r;
    r.v = v; r.wr = wr; r.addr = addr; r.data = data; r.rd = rd;
    r.gnt = gnt; r.rv = rv; r.din = din;
    r.e_rdy = e_rdy; r.e_ldv = e_ldv; r.e_ldd = e_ldd; r.e_rd = e_rd;
    r.e_men = e_men; r.e_mwr = e_mwr; r.e_maddr = e_maddr;
    r.e_mdout = e_mdout; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic wr, logic [31:0] a,
                       logic [63:0] d, logic [4:0] rd);
    req_valid = v; req_wr = wr; req_addr = a; req_data = d; req_rd = rd;
  endtask

  task automatic idle_in;
    drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0);
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_d_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_a [4];
    logic [63:0] exp_d [4];
    int n;

    reset = 1'b1;
    idle_in();
    // Cycle table: store/forward, youngest match + ordered drain, load miss.
    //           v  wr addr      data   rd gnt rv din        rdy ldv ldd    rdq men mwr maddr     mdout  cnt
    tbl.push_back(mk(1,1,32'h40, 64'h11,0, 0,0,64'h0,     1,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(1,0,32'h40, 64'h0, 3, 0,0,64'h0,     1,0,64'h0,  0, 0,0,32'h0,   64'h0, 1));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 0,0,64'h0,     0,1,64'h11, 3, 1,1,32'h40,  64'h11,1));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 1,0,64'h0,     0,0,64'h0,  0, 1,1,32'h40,  64'h11,1));
    tbl.push_back(mk(1,1,32'h30, 64'h5, 0, 0,0,64'h0,     1,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(1,1,32'h8,  64'hA, 0, 0,0,64'h0,     1,0,64'h0,  0, 0,0,32'h0,   64'h0, 1));
    tbl.push_back(mk(1,1,32'h8,  64'hB, 0, 0,0,64'h0,     1,0,64'h0,  0, 1,1,32'h30,  64'h5, 2));
    tbl.push_back(mk(1,0,32'h8,  64'h0, 7, 1,0,64'h0,     0,0,64'h0,  0, 1,1,32'h30,  64'h5, 3));
    tbl.push_back(mk(1,0,32'h8,  64'h0, 7, 0,0,64'h0,     1,0,64'h0,  0, 0,0,32'h0,   64'h0, 2));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 1,0,64'h0,     0,1,64'hB,  7, 1,1,32'h8,   64'hA, 2));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 0,0,64'h0,     0,0,64'h0,  0, 0,0,32'h0,   64'h0, 1));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 1,0,64'h0,     0,0,64'h0,  0, 1,1,32'h8,   64'hB, 1));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,0,64'h0,     0,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,0,64'h0,     0,0,64'h0,  0, 1,0,32'h100, 64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,0,64'h0,     0,0,64'h0,  0, 1,0,32'h100, 64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 1,0,64'h0,     0,0,64'h0,  0, 1,0,32'h100, 64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,0,64'h0,     0,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,0,64'h0,     0,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,1,64'hDEAD,  0,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(1,0,32'h100,64'h0, 9, 0,0,64'h0,     1,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 0,1,64'hBAD,   0,1,64'hDEAD,9,0,0,32'h0,   64'h0, 0));
    tbl.push_back(mk(0,0,32'h0,  64'h0, 0, 0,0,64'h0,     0,0,64'h0,  0, 0,0,32'h0,   64'h0, 0));

    tick();
    drive(1'b1, 1'b1, 32'h40, 64'h11, 5'd0);
    #4;
    chk("rst_ready", req_ready, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_rd", ld_rd, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_mem_en", mif.mem_en, 0);
    chk("rst_mem_wr_en", mif.mem_wr_en, 0);
    chk("rst_count", sb_count, 0);
    chk("rst_empty", sb_empty, 1);
    tick();
    idle_in();
    reset = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].rd);
      mif.mem_gnt = tbl[i].gnt;
      mif.mem_rvalid = tbl[i].rv;
      mif.mem_d_in = tbl[i].din;
      #4;
      chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_ld_valid", i), ld_valid, tbl[i].e_ldv);
      if (tbl[i].e_ldv) begin
        chk($sformatf("v%0d_ld_data", i), ld_data, tbl[i].e_ldd);
        chk($sformatf("v%0d_ld_rd", i), ld_rd, tbl[i].e_rd);
      end
      chk($sformatf("v%0d_mem_en", i), mif.mem_en, tbl[i].e_men);
      chk($sformatf("v%0d_mem_wr_en", i), mif.mem_wr_en, tbl[i].e_mwr);
      if (tbl[i].e_men)
        chk($sformatf("v%0d_mem_addr", i), mif.mem_addr, tbl[i].e_maddr);
      if (tbl[i].e_mwr)
        chk($sformatf("v%0d_mem_d_out", i), mif.mem_d_out, tbl[i].e_mdout);
      chk($sformatf("v%0d_count", i), sb_count, tbl[i].e_cnt);
      tick();
    end
    idle_in();

    // Full buffer: five stores with no grant, then a single grant.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(8 * k), 64'(k + 1), 5'd0);
      #4;
      chk($sformatf("full_st%0d_ready", k), req_ready, 1);
      tick();
    end
    drive(1'b1, 1'b1, 32'h220, 64'd5, 5'd0);
    #4;
    chk("full_st4_stall", req_ready, 0);
    chk("full_count4", sb_count, 4);
    tick();
    mif.mem_gnt = 1'b1;
    #4;
    chk("full_pop_no_bypass", req_ready, 0);
    chk("full_pop_count", sb_count, 4);
    chk("full_pop_addr", mif.mem_addr, 32'h200);
    tick();
    mif.mem_gnt = 1'b0;
    #4;
    chk("full_st4_accept", req_ready, 1);
    chk("full_after_pop_count", sb_count, 3);
    tick();
    idle_in();
    #4;
    chk("full_refill_count", sb_count, 4);
    chk("full_head_addr", mif.mem_addr, 32'h208);
    tick();

    exp_a[0] = 32'h208; exp_a[1] = 32'h210; exp_a[2] = 32'h218; exp_a[3] = 32'h220;
    exp_d[0] = 64'd2;   exp_d[1] = 64'd3;   exp_d[2] = 64'd4;   exp_d[3] = 64'd5;
    mif.mem_gnt = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #4;
      if (mif.mem_en && mif.mem_wr_en) begin
        chk($sformatf("drain%0d_addr", n), mif.mem_addr, exp_a[n]);
        chk($sformatf("drain%0d_data", n), mif.mem_d_out, exp_d[n]);
        n++;
      end
      tick();
    end
    mif.mem_gnt = 1'b0;
    chk("drain_writes", n, 4);
    #4;
    chk("drain_empty", sb_empty, 1);
    tick();

    // Reset during LD_WAIT with a store still buffered.
    drive(1'b1, 1'b1, 32'h300, 64'h77, 5'd0);
    tick();
    drive(1'b1, 1'b0, 32'h400, 64'h0, 5'd4);
    #4;
    chk("rA_miss_ready", req_ready, 0);
    tick();
    mif.mem_gnt = 1'b1;
    #4;
    chk("rA_ldreq_en", mif.mem_en, 1);
    chk("rA_ldreq_wr", mif.mem_wr_en, 0);
    chk("rA_ldreq_addr", mif.mem_addr, 32'h400);
    tick();
    mif.mem_gnt = 1'b0;
    #1;
    chk("rA_wait_count", sb_count, 1);
    reset = 1'b1;
    #1;
    chk("rA_rst_en", mif.mem_en, 0);
    chk("rA_rst_count", sb_count, 0);
    chk("rA_rst_ready", req_ready, 0);
    tick();
    idle_in();
    reset = 1'b0;
    mif.mem_rvalid = 1'b1;
    mif.mem_d_in = 64'hBEEF;
    for (int c = 0; c < 4; c++) begin
      #4;
      chk($sformatf("rA_post%0d_ld_valid", c), ld_valid, 0);
      chk($sformatf("rA_post%0d_mem_en", c), mif.mem_en, 0);
      tick();
      mif.mem_rvalid = 1'b0;
    end

    // Reset during ST_REQ.
    drive(1'b1, 1'b1, 32'h500, 64'h99, 5'd0);
    tick();
    idle_in();
    tick();
    chk("rB_streq_en", mif.mem_en, 1);
    chk("rB_streq_wr", mif.mem_wr_en, 1);
    reset = 1'b1;
    #1;
    chk("rB_rst_en", mif.mem_en, 0);
    chk("rB_rst_wr", mif.mem_wr_en, 0);
    chk("rB_rst_count", sb_count, 0);
    chk("rB_rst_empty", sb_empty, 1);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("rB_post%0d_mem_en", c), mif.mem_en, 0);
      chk($sformatf("rB_post%0d_ld_valid", c), ld_valid, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
